i2c_byte_master: RTL
====================

// Module: i2c_byte_master
// PURPOSE
//  Hardware I2C master that replaces CPU bit-banging of SCL/SDA for the G-sensor link.
//  Sits downstream of the cpu: memory-mapped SW/LW glue drives the command port.
//  Converts one command per handshake (START/STOP/WRITE byte/READ byte) into open-drain
//  bus waveforms and returns a one-cycle response (read data, ACK bit, error).
// PARAMETERS
//  QDIV   31  clk cycles per quarter-bit minus 1 (50 MHz / (4*32) = ~390 kHz SCL)
//  QDIV_W  6  width of quarter-bit counter; must hold QDIV
// PORTS
//  clk         in   1  system clock, single clock domain
//  rst         in   1  synchronous reset, active-high
//  cmd_valid   in   1  command present
//  cmd_ready   out  1  block idle, accepts command this cycle
//  cmd         in   2  0=START (or repeated START), 1=STOP, 2=WRITE, 3=READ
//  wr_data     in   8  byte for WRITE, sent MSB first
//  rd_nack     in   1  READ only: 1=master NACKs (last byte), 0=master ACKs
//  rsp_valid   out  1  one-cycle pulse when a command completes
//  rd_data     out  8  byte received by READ, valid with rsp_valid
//  ack_n       out  1  WRITE: SDA level sampled in ACK slot (0=slave ACK)
//  err         out  1  with rsp_valid: command illegal in current bus state
//  bus_held    out  1  1 between completed START and completed STOP
//  scl_o       out  1  SCL level (push-pull; slave clock stretching unsupported)
//  sda_oe      out  1  1 = pull SDA low; 0 = release (pad: sda = oe ? 0 : 'bz)
//  sda_i       in   1  SDA pad input
// BEHAVIOUR
//  Reset: IDLE, cmd_ready=1, rsp_valid=0, rd_data=0, ack_n=1, err=0, bus_held=0,
//   scl_o=1, sda_oe=0, quarter counter=0. Reset mid-transfer aborts on the next edge;
//   bus left unterminated, software must issue START then STOP.
//  Handshake: accept when cmd_valid & cmd_ready; cmd, wr_data, rd_nack captured then.
//   cmd_ready deasserts the cycle after acceptance, reasserts the cycle rsp_valid pulses.
//  Timing: a quarter (Q) lasts QDIV+1 clk; a slot = Q0..Q3. Data slot: Q0 scl=0 and
//   sda_oe updates at Q0 start; Q1,Q2 scl=1; Q3 scl=0. sda_i sampled on last clk of Q1.
//  States: IDLE, START, BITS, ACK, STOP, RESP.
//   START (1 slot): Q0 sda_oe=0, scl held; Q1 scl=1; Q2 sda_oe=1; Q3 scl=0.
//     Legal with bus_held=0 or 1 (repeated start). Sets bus_held.
//   WRITE: BITS 8 slots driving wr_data[7..0] (sda_oe = ~bit), then ACK slot with
//     sda_oe=0, ack_n <= sampled sda_i. NACK is reported, not an error.
//   READ: BITS 8 slots with sda_oe=0, shift sda_i in MSB first; ACK slot drives
//     sda_oe = ~rd_nack. rd_data updated at completion.
//   STOP (1 slot): Q0 sda_oe=1, scl=0; Q1,Q2 scl=1; Q2 start sda_oe=0; Q3 scl=1.
//     Clears bus_held; bus ends scl=1, sda released.
//   RESP: single cycle, rsp_valid=1, return to IDLE.
//  Latency accept->rsp_valid: START/STOP 4*(QDIV+1)+1; WRITE/READ 36*(QDIV+1)+1 clk.
//  Errors: WRITE/READ/STOP with bus_held=0 -> no bus activity, next cycle RESP with
//   err=1; rd_data, ack_n unchanged.
//  Idle outputs: bus_held=1 -> scl_o=0, sda_oe=0; bus_held=0 -> scl_o=1, sda_oe=0.
//  Bit counter 0..7 wraps only via state exit; quarter counter resets each Q.
// TESTING (QDIV=3 for sim; slave model on sda_i)
//  Reset: assert rst 2 cycles -> scl_o=1, sda_oe=0, cmd_ready=1, bus_held=0.
//  START then WRITE 0x3A, slave ACKs -> SDA falls while SCL=1; bits 0,0,1,1,1,0,1,0
//   stable across SCL high; rsp_valid with ack_n=0, err=0; WRITE latency 145 clk.
//  WRITE 0x1D, slave releases SDA in ACK slot -> ack_n=1, err=0, bus_held stays 1.
//  READ rd_nack=1, slave sends 0xA5 -> rd_data=8'hA5, sda_oe=0 in 9th slot.
//  WRITE while bus_held=0 -> rsp_valid 2 cycles after accept, err=1, scl_o stays 1.
//  rst asserted mid-READ (bit 4) -> next edge scl_o=1, sda_oe=0, cmd_ready=1, no rsp.

Source files
------------

// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level I2C master for the G-sensor link.
// Takes one START/STOP/WRITE/READ command per handshake, generates the
// SCL/SDA waveforms (open-drain SDA via sda_oe), and returns a one-cycle
// response carrying read data, the slave ACK bit, or an error flag.
module i2c_byte_master #(
  parameter int QDIV   = 31,
  parameter int QDIV_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       rd_nack,
  output logic       rsp_valid,
  output logic [7:0] rd_data,
  output logic       ack_n,
  output logic       err,
  output logic       bus_held,
  output logic       scl_o,
  output logic       sda_oe,
  input  logic       sda_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BITS, S_ACK, S_STOP, S_RESP
  } state_t;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd3;

  localparam logic [QDIV_W-1:0] QMAX = QDIV_W'(QDIV);
  localparam logic [QDIV_W-1:0] QONE = QDIV_W'(1);

  state_t            state_q, state_d;
  logic [QDIV_W-1:0] qcnt_q, qcnt_d;
  logic [1:0]        phase_q, phase_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              is_read_q, is_read_d;
  logic              nack_q, nack_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              ack_n_q, ack_n_d;
  logic              err_q, err_d;
  logic              bus_held_q, bus_held_d;
  logic              err_wait_q, err_wait_d;

  logic tick, sample, slot_end, accept, on_bus;

  // Quarter/slot timing strobes and the command handshake.
  assign tick      = (qcnt_q == QMAX);
  assign sample    = tick && (phase_q == 2'd1);
  assign slot_end  = tick && (phase_q == 2'd3);
  assign on_bus    = (state_q == S_START) || (state_q == S_BITS) ||
                     (state_q == S_ACK)   || (state_q == S_STOP);
  // An illegal command spends one decode cycle in RESP before the pulse.
  assign rsp_valid = (state_q == S_RESP) && !err_wait_q;
  assign cmd_ready = (state_q == S_IDLE) || rsp_valid;
  assign accept    = cmd_valid && cmd_ready;

  assign rd_data  = rd_data_q;
  assign ack_n    = ack_n_q;
  assign err      = err_q;
  assign bus_held = bus_held_q;

  // Next-state: command decode, quarter/bit sequencing, sampling of SDA.
  always_comb begin
    state_d    = state_q;
    qcnt_d     = qcnt_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    is_read_d  = is_read_q;
    nack_d     = nack_q;
    rd_data_d  = rd_data_q;
    ack_n_d    = ack_n_q;
    err_d      = err_q;
    bus_held_d = bus_held_q;
    err_wait_d = 1'b0;

    if (on_bus) begin
      qcnt_d = tick ? '0 : qcnt_q + QONE;
      if (tick) phase_d = phase_q + 2'd1;
    end

    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          qcnt_d    = '0;
          phase_d   = 2'd0;
          bit_cnt_d = 3'd0;
          is_read_d = (cmd == CMD_READ);
          nack_d    = rd_nack;
          shift_d   = wr_data;
          err_d     = 1'b0;
          if (cmd == CMD_START) begin
            state_d = S_START;
          end else if (!bus_held_q) begin
            // No transaction open: report without touching the bus.
            state_d    = S_RESP;
            err_d      = 1'b1;
            err_wait_d = 1'b1;
          end else if (cmd == CMD_STOP) begin
            state_d = S_STOP;
          end else begin
            state_d = S_BITS;
          end
        end else if (state_q == S_RESP && !err_wait_q) begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (slot_end) begin
          state_d    = S_RESP;
          bus_held_d = 1'b1;
        end
      end
      S_BITS: begin
        if (sample && is_read_q) shift_d = {shift_q[6:0], sda_i};
        if (slot_end) begin
          if (bit_cnt_q == 3'd7) begin
            state_d   = S_ACK;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_ACK: begin
        if (sample && !is_read_q) ack_n_d = sda_i;
        if (slot_end) begin
          state_d = S_RESP;
          if (is_read_q) rd_data_d = shift_q;
        end
      end
      S_STOP: begin
        if (slot_end) begin
          state_d    = S_RESP;
          bus_held_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus pins decoded from state and quarter; SDA only changes while SCL is low
  // except for the START fall and STOP rise.
  always_comb begin
    scl_o  = ~bus_held_q;
    sda_oe = 1'b0;
    unique case (state_q)
      S_START: begin
        unique case (phase_q)
          2'd0: begin scl_o = ~bus_held_q; sda_oe = 1'b0; end
          2'd1: begin scl_o = 1'b1;        sda_oe = 1'b0; end
          2'd2: begin scl_o = 1'b1;        sda_oe = 1'b1; end
          default: begin scl_o = 1'b0;     sda_oe = 1'b1; end
        endcase
      end
      S_BITS: begin
        scl_o  = (phase_q == 2'd1) || (phase_q == 2'd2);
        sda_oe = is_read_q ? 1'b0 : ~shift_q[3'd7 - bit_cnt_q];
      end
      S_ACK: begin
        scl_o  = (phase_q == 2'd1) || (phase_q == 2'd2);
        sda_oe = is_read_q ? ~nack_q : 1'b0;
      end
      S_STOP: begin
        unique case (phase_q)
          2'd0: begin scl_o = 1'b0;    sda_oe = 1'b1; end
          2'd1: begin scl_o = 1'b1;    sda_oe = 1'b1; end
          default: begin scl_o = 1'b1; sda_oe = 1'b0; end
        endcase
      end
      default: begin
        scl_o  = ~bus_held_q;
        sda_oe = 1'b0;
      end
    endcase
  end

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      qcnt_q     <= '0;
      phase_q    <= 2'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      is_read_q  <= 1'b0;
      nack_q     <= 1'b0;
      rd_data_q  <= 8'h00;
      ack_n_q    <= 1'b1;
      err_q      <= 1'b0;
      bus_held_q <= 1'b0;
      err_wait_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      is_read_q  <= is_read_d;
      nack_q     <= nack_d;
      rd_data_q  <= rd_data_d;
      ack_n_q    <= ack_n_d;
      err_q      <= err_d;
      bus_held_q <= bus_held_d;
      err_wait_q <= err_wait_d;
    end
  end

endmodule
